// File: rtl/mem_block_mover_if.sv
// Bus bundle for the block mover: transfer request, CPU-side memory request,
// and the data-memory port that the mover drives.
interface mem_block_mover_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  mode;
  logic [ADDR_WIDTH-1:0] srcAddr;
  logic [ADDR_WIDTH-1:0] dstAddr;
  logic [ADDR_WIDTH-1:0] length;
  logic [DATA_WIDTH-1:0] fillValue;
  logic [ADDR_WIDTH-1:0] cpuAddress;
  logic [DATA_WIDTH-1:0] cpuDataIn;
  logic                  cpuReadWrite;
  logic [DATA_WIDTH-1:0] memDataOut;
  logic [ADDR_WIDTH-1:0] memAddress;
  logic [DATA_WIDTH-1:0] memDataIn;
  logic                  memReadWrite;
  logic                  busy;
  logic                  done;

  modport master (
    output start, mode, srcAddr, dstAddr, length, fillValue,
    output cpuAddress, cpuDataIn, cpuReadWrite, memDataOut,
    input  memAddress, memDataIn, memReadWrite, busy, done
  );

  modport slave (
    input  start, mode, srcAddr, dstAddr, length, fillValue,
    input  cpuAddress, cpuDataIn, cpuReadWrite, memDataOut,
    output memAddress, memDataIn, memReadWrite, busy, done
  );
endinterface

// File: rtl/mem_block_mover.sv
// Byte-at-a-time copy/fill engine sitting in front of the data memory; the CPU
// request passes straight through whenever no transfer is running.
module mem_block_mover #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  mem_block_mover_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state;
  state_t                state_next;
  logic                  fill_mode;
  logic [ADDR_WIDTH-1:0] src_base;
  logic [ADDR_WIDTH-1:0] dst_base;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] index;
  logic [ADDR_WIDTH-1:0] index_inc;
  logic [DATA_WIDTH-1:0] fill_byte;
  logic [DATA_WIDTH-1:0] buffer;

  assign index_inc = index + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fill_mode <= 1'b0;
      src_base  <= '0;
      dst_base  <= '0;
      count     <= '0;
      index     <= '0;
      fill_byte <= '0;
      buffer    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.start) begin
            fill_mode <= bus.mode;
            src_base  <= bus.srcAddr;
            dst_base  <= bus.dstAddr;
            count     <= bus.length;
            fill_byte <= bus.fillValue;
            index     <= '0;
          end
        end
        READ:    buffer <= bus.memDataOut;
        WRITE:   index  <= index_inc;
        default: ;
      endcase
    end
  end

  // The memory port is muxed to the CPU unless a byte is being moved; while
  // reset is asserted it is forced back to the CPU so an aborted transfer
  // cannot land one more write on the reset edge.
  always_comb begin
    state_next       = state;
    bus.memAddress   = bus.cpuAddress;
    bus.memDataIn    = bus.cpuDataIn;
    bus.memReadWrite = bus.cpuReadWrite;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.length == '0)  state_next = DONE;
          else if (bus.mode)     state_next = WRITE;
          else                   state_next = READ;
        end
      end
      READ: begin
        bus.busy         = 1'b1;
        bus.memAddress   = src_base + index;
        bus.memReadWrite = 1'b0;
        state_next       = WRITE;
      end
      WRITE: begin
        bus.busy         = 1'b1;
        bus.memAddress   = dst_base + index;
        bus.memDataIn    = fill_mode ? fill_byte : buffer;
        bus.memReadWrite = 1'b1;
        if (index_inc == count) state_next = DONE;
        else if (fill_mode)     state_next = WRITE;
        else                    state_next = READ;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (reset) begin
      bus.memAddress   = bus.cpuAddress;
      bus.memDataIn    = bus.cpuDataIn;
      bus.memReadWrite = bus.cpuReadWrite;
    end
  end

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: behavioural data memory, a reference memory image,
// and a queue of expected block-mover writes matched against the memory port.
module tb_mem_block_mover;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  wr_t        exp_q [$];
  int         checks = 0;
  int         passed = 0;

  mem_block_mover_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  mem_block_mover #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.memDataOut = mem[bus.memAddress];

  always @(posedge clk) begin
    if (bus.memReadWrite) mem[bus.memAddress] <= bus.memDataIn;
  end

  // Any write the CPU is not asking for must be the next expected mover write.
  always @(negedge clk) begin
    #2;
    if (!reset && bus.memReadWrite && (bus.busy || !bus.cpuReadWrite)) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL block_write: unexpected write addr=%02h data=%02h, none expected",
                 bus.memAddress, bus.memDataIn);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.memAddress !== e.addr || bus.memDataIn !== e.data)
          $display("[TB] FAIL block_write: got addr=%02h data=%02h, expected addr=%02h data=%02h",
                   bus.memAddress, bus.memDataIn, e.addr, e.data);
        else
          passed++;
      end
    end
  end

  function automatic int count_mem_diffs();
    int n = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  function automatic logic [7:0] preload_byte(input int a);
    return 8'(a * 7 + 3);
  endfunction

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    bus.cpuAddress   = a;
    bus.cpuDataIn    = d;
    bus.cpuReadWrite = 1'b1;
    @(negedge clk);
    bus.cpuReadWrite = 1'b0;
    ref_mem[a]       = d;
  endtask

  // Drives one start pulse and pushes the first push_limit writes the model predicts.
  task automatic start_transfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                                input logic [7:0] len, input logic [7:0] f,
                                input int push_limit);
    logic [7:0] sa;
    logic [7:0] da;
    wr_t        w;
    bus.start     = 1'b1;
    bus.mode      = m;
    bus.srcAddr   = s;
    bus.dstAddr   = d;
    bus.length    = len;
    bus.fillValue = f;
    for (int i = 0; i < int'(len) && i < push_limit; i++) begin
      sa = s + 8'(i);
      da = d + 8'(i);
      ref_mem[da] = m ? f : ref_mem[sa];
      w.addr = da;
      w.data = ref_mem[da];
      exp_q.push_back(w);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_transfer(input int max_cycles, output int busy_n,
                               output int done_at, output int done_n);
    busy_n  = 0;
    done_at = -1;
    done_n  = 0;
    for (int c = 1; c <= max_cycles; c++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      @(negedge clk);
      if (done_at >= 0 && c >= done_at + 2) break;
    end
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.mode         = 1'b0;
    bus.srcAddr      = '0;
    bus.dstAddr      = '0;
    bus.length       = '0;
    bus.fillValue    = '0;
    bus.cpuAddress   = 8'h05;
    bus.cpuDataIn    = 8'h66;
    bus.cpuReadWrite = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy);
    else passed++;
    checks++;
    if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b, expected 0", bus.done);
    else passed++;
    checks++;
    if (bus.memAddress !== 8'h05 || bus.memDataIn !== 8'h66 || bus.memReadWrite !== 1'b0)
      $display("[TB] FAIL reset_passthrough: got addr=%02h data=%02h rw=%b, expected 05/66/0",
               bus.memAddress, bus.memDataIn, bus.memReadWrite);
    else passed++;
    for (int i = 0; i < 256; i++) cpu_write(8'(i), preload_byte(i));
    checks++;
    if (count_mem_diffs() != 0)
      $display("[TB] FAIL preload_image: %0d bytes differ, expected 0", count_mem_diffs());
    else passed++;
  endtask

  task automatic test_fill();
    int bn, da, dn;
    start_transfer(1'b1, 8'h00, 8'h10, 8'd4, 8'hA5, 256);
    wait_transfer(40, bn, da, dn);
    checks++;
    if (bn != 4 || da != 5 || dn != 1)
      $display("[TB] FAIL fill_timing: got busy=%0d done_at=%0d dones=%0d, expected 4/5/1", bn, da, dn);
    else passed++;
    for (int i = 8'h10; i <= 8'h13; i++) begin
      checks++;
      if (mem[i] !== 8'hA5) $display("[TB] FAIL fill_byte[%02h]: got %02h, expected a5", i, mem[i]);
      else passed++;
    end
    checks++;
    if (mem[8'h14] !== preload_byte(8'h14))
      $display("[TB] FAIL fill_guard: got %02h, expected %02h", mem[8'h14], preload_byte(8'h14));
    else passed++;
  endtask

  task automatic test_copy();
    int bn, da, dn;
    cpu_write(8'h20, 8'h11);
    cpu_write(8'h21, 8'h22);
    cpu_write(8'h22, 8'h33);
    start_transfer(1'b0, 8'h20, 8'h40, 8'd3, 8'h00, 256);
    wait_transfer(40, bn, da, dn);
    checks++;
    if (bn != 6 || da != 7 || dn != 1)
      $display("[TB] FAIL copy_timing: got busy=%0d done_at=%0d dones=%0d, expected 6/7/1", bn, da, dn);
    else passed++;
    checks++;
    if ({mem[8'h40], mem[8'h41], mem[8'h42]} !== 24'h112233)
      $display("[TB] FAIL copy_data: got %02h %02h %02h, expected 11 22 33",
               mem[8'h40], mem[8'h41], mem[8'h42]);
    else passed++;
  endtask

  task automatic test_wrap_overlap();
    int bn, da, dn;
    start_transfer(1'b1, 8'h00, 8'hFE, 8'd4, 8'h5A, 256);
    wait_transfer(40, bn, da, dn);
    checks++;
    if (bn != 4 || da != 5 || dn != 1)
      $display("[TB] FAIL wrap_timing: got busy=%0d done_at=%0d dones=%0d, expected 4/5/1", bn, da, dn);
    else passed++;
    checks++;
    if ({mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]} !== 32'h5A5A5A5A)
      $display("[TB] FAIL wrap_data: got %02h %02h %02h %02h, expected 5a x4",
               mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]);
    else passed++;
    cpu_write(8'h30, 8'h77);
    start_transfer(1'b0, 8'h30, 8'h31, 8'd3, 8'h00, 256);
    wait_transfer(40, bn, da, dn);
    checks++;
    if (bn != 6 || da != 7 || dn != 1)
      $display("[TB] FAIL overlap_timing: got busy=%0d done_at=%0d dones=%0d, expected 6/7/1", bn, da, dn);
    else passed++;
    checks++;
    if ({mem[8'h31], mem[8'h32], mem[8'h33]} !== 24'h777777)
      $display("[TB] FAIL overlap_data: got %02h %02h %02h, expected 77 77 77",
               mem[8'h31], mem[8'h32], mem[8'h33]);
    else passed++;
  endtask

  task automatic test_length_zero();
    int bn, da, dn;
    start_transfer(1'b1, 8'h00, 8'h70, 8'd0, 8'hEE, 256);
    wait_transfer(20, bn, da, dn);
    checks++;
    if (bn != 0 || da != 1 || dn != 1)
      $display("[TB] FAIL zero_timing: got busy=%0d done_at=%0d dones=%0d, expected 0/1/1", bn, da, dn);
    else passed++;
    checks++;
    if (mem[8'h70] !== preload_byte(8'h70))
      $display("[TB] FAIL zero_nowrite: got %02h, expected %02h", mem[8'h70], preload_byte(8'h70));
    else passed++;
  endtask

  task automatic test_ignored_start();
    int bn, da, dn;
    start_transfer(1'b0, 8'h40, 8'h48, 8'd3, 8'h00, 256);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.mode      = 1'b1;
    bus.srcAddr   = 8'h00;
    bus.dstAddr   = 8'h90;
    bus.length    = 8'd2;
    bus.fillValue = 8'hEE;
    @(negedge clk);
    bus.start = 1'b0;
    wait_transfer(40, bn, da, dn);
    checks++;
    if (bn != 4 || da != 5 || dn != 1)
      $display("[TB] FAIL ignored_start_timing: got busy=%0d done_at=%0d dones=%0d, expected 4/5/1",
               bn, da, dn);
    else passed++;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || mem[8'h90] !== preload_byte(8'h90))
      $display("[TB] FAIL ignored_start_effect: busy=%b mem90=%02h, expected 0/%02h",
               bus.busy, mem[8'h90], preload_byte(8'h90));
    else passed++;
    checks++;
    if ({mem[8'h48], mem[8'h49], mem[8'h4A]} !== 24'h112233)
      $display("[TB] FAIL ignored_start_data: got %02h %02h %02h, expected 11 22 33",
               mem[8'h48], mem[8'h49], mem[8'h4A]);
    else passed++;
  endtask

  task automatic test_passthrough();
    cpu_write(8'h50, 8'h9C);
    checks++;
    if (mem[8'h50] !== 8'h9C) $display("[TB] FAIL cpu_write: got %02h, expected 9c", mem[8'h50]);
    else passed++;
    start_transfer(1'b1, 8'h00, 8'h60, 8'd2, 8'h42, 256);
    bus.cpuAddress   = 8'h50;
    bus.cpuDataIn    = 8'h3C;
    bus.cpuReadWrite = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || mem[8'h50] !== 8'h9C)
      $display("[TB] FAIL cpu_blocked: done=%b mem50=%02h, expected 1/9c", bus.done, mem[8'h50]);
    else passed++;
    bus.cpuReadWrite = 1'b0;
    @(negedge clk);
    checks++;
    if (mem[8'h60] !== 8'h42 || mem[8'h61] !== 8'h42)
      $display("[TB] FAIL blocked_fill: got %02h %02h, expected 42 42", mem[8'h60], mem[8'h61]);
    else passed++;
  endtask

  task automatic test_reset_mid_transfer();
    int dn = 0;
    int bn = 0;
    start_transfer(1'b1, 8'h00, 8'h80, 8'd8, 8'hC3, 3);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b, expected 0", bus.busy);
    else passed++;
    for (int c = 0; c < 12; c++) begin
      if (bus.done) dn++;
      if (bus.busy) bn++;
      @(negedge clk);
    end
    checks++;
    if (dn != 0 || bn != 0)
      $display("[TB] FAIL abort_quiet: dones=%0d busy=%0d, expected 0/0", dn, bn);
    else passed++;
    for (int i = 8'h80; i <= 8'h87; i++) begin
      checks++;
      if (mem[i] !== ((i <= 8'h82) ? 8'hC3 : preload_byte(i)))
        $display("[TB] FAIL abort_byte[%02h]: got %02h, expected %02h", i, mem[i],
                 (i <= 8'h82) ? 8'hC3 : preload_byte(i));
      else passed++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_wrap_overlap();
    test_length_zero();
    test_ignored_start();
    test_passthrough();
    test_reset_mid_transfer();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0)
      $display("[TB] FAIL sb_drain: %0d expected writes never seen, expected 0", exp_q.size());
    else passed++;
    checks++;
    if (count_mem_diffs() != 0)
      $display("[TB] FAIL mem_image: %0d bytes differ from model, expected 0", count_mem_diffs());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
